// File: rtl/ex_muldiv_unit.sv
// Iterative MUL/DIV/DIVU/REM for the EX stage: start -> result_valid after XLEN+1 cycles.
// Backpressure: hold_out freezes ID/EX from the start cycle through BUSY; drops in DONE so the pipe advances.
module ex_muldiv_unit #(
    parameter int          XLEN     = 32,
    parameter logic [4:0]  ALU_MUL  = 5'd12,
    parameter logic [4:0]  ALU_DIV  = 5'd13,
    parameter logic [4:0]  ALU_DIVU = 5'd14,
    parameter logic [4:0]  ALU_REM  = 5'd15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [4:0]      aluctrl,
    input  logic [XLEN-1:0] operand_1,
    input  logic [XLEN-1:0] operand_2,
    input  logic [4:0]      destReg,
    input  logic            kill,
    output logic            hold_out,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      result_dest
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   counter;
    logic [4:0]      op_q;
    logic [4:0]      dest_q;
    logic [XLEN-1:0] acc;       // product (MUL) or partial remainder (DIV/REM)
    logic [XLEN-1:0] sh;        // multiplier shifting out, or dividend shifting out / quotient shifting in
    logic [XLEN-1:0] opnd;      // multiplicand shifting left, or |divisor|
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] result_q;
    logic [4:0]      result_dest_q;

    logic            is_muldiv;
    logic            start;
    logic            signed_div;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] final_val;

    assign is_muldiv  = (aluctrl == ALU_MUL) || (aluctrl == ALU_DIV) ||
                        (aluctrl == ALU_DIVU) || (aluctrl == ALU_REM);
    assign start      = (state == IDLE) && valid_in && !kill && is_muldiv && !rst;
    assign signed_div = (aluctrl == ALU_DIV) || (aluctrl == ALU_REM);
    assign a_neg      = signed_div && operand_1[XLEN-1];
    assign b_neg      = signed_div && operand_2[XLEN-1];
    assign abs_a      = a_neg ? -operand_1 : operand_1;
    assign abs_b      = b_neg ? -operand_2 : operand_2;

    // Restoring step: the remainder never exceeds 2*divisor-1, so XLEN+1 bits cannot wrap.
    assign rem_shift  = {acc, sh[XLEN-1]};
    assign trial      = rem_shift - {1'b0, opnd};

    always_comb begin
        final_val = acc;
        if (op_q == ALU_DIV || op_q == ALU_DIVU) begin
            final_val = neg_q ? -sh : sh;
        end else if (op_q == ALU_REM) begin
            final_val = neg_r ? -acc : acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = BUSY;
            BUSY: begin
                if (kill) begin
                    state_nxt = IDLE;
                end else if (counter == CW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter       <= '0;
            op_q          <= '0;
            dest_q        <= '0;
            acc           <= '0;
            sh            <= '0;
            opnd          <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            result_q      <= '0;
            result_dest_q <= '0;
        end else if (start) begin
            counter <= CW'(XLEN);
            op_q    <= aluctrl;
            dest_q  <= destReg;
            acc     <= '0;
            // MUL keeps only the low XLEN bits, which are sign-agnostic, so raw operands suffice
            sh      <= (aluctrl == ALU_MUL) ? operand_2 : abs_a;
            opnd    <= (aluctrl == ALU_MUL) ? operand_1 : abs_b;
            // Divide by zero must leave the all-ones quotient un-negated
            neg_q   <= (aluctrl == ALU_DIV) && (a_neg ^ b_neg) && (operand_2 != '0);
            neg_r   <= (aluctrl == ALU_REM) && a_neg;
        end else if (state == BUSY) begin
            counter <= counter - CW'(1);
            if (op_q == ALU_MUL) begin
                if (sh[0]) acc <= acc + opnd;
                opnd <= opnd << 1;
                sh   <= sh >> 1;
            end else if (!trial[XLEN]) begin
                acc <= trial[XLEN-1:0];
                sh  <= {sh[XLEN-2:0], 1'b1};
            end else begin
                acc <= rem_shift[XLEN-1:0];
                sh  <= {sh[XLEN-2:0], 1'b0};
            end
        end else if (state == DONE && !kill) begin
            result_q      <= final_val;
            result_dest_q <= dest_q;
        end
    end

    assign busy         = (state == BUSY);
    assign hold_out     = start || busy;
    assign result_valid = (state == DONE) && !kill;
    assign result       = result_valid ? final_val : result_q;
    assign result_dest  = result_valid ? dest_q : result_dest_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Drives ex_muldiv_unit like an ID/EX register that honours hold_out; a scoreboard queue
// holds reference results and expected arrival cycles, checked by an independent monitor.
module tb_ex_muldiv_unit;

    localparam int         XLEN    = 32;
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_MUL  = 5'd12;
    localparam logic [4:0] OP_DIV  = 5'd13;
    localparam logic [4:0] OP_DIVU = 5'd14;
    localparam logic [4:0] OP_REM  = 5'd15;

    logic            clk;
    logic            rst;
    logic            valid_in;
    logic [4:0]      aluctrl;
    logic [XLEN-1:0] operand_1;
    logic [XLEN-1:0] operand_2;
    logic [4:0]      destReg;
    logic            kill;
    logic            hold_out;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      result_dest;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  dest;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    ex_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .aluctrl      (aluctrl),
        .operand_1    (operand_1),
        .operand_2    (operand_2),
        .destReg      (destReg),
        .kill         (kill),
        .hold_out     (hold_out),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .result_dest  (result_dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [63:0] p;
        sa = a;
        sb = b;
        case (op)
            OP_MUL: begin
                p = sa * sb;
                return p[31:0];
            end
            OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            OP_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            OP_DIVU: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            default: return 32'd0;
        endcase
    endfunction

    // Present one instruction and keep it at ID/EX until hold_out releases it.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dest);
        int   holds;
        bit   md;
        exp_t e;
        @(negedge clk);
        valid_in  = 1'b1;
        aluctrl   = op;
        operand_1 = a;
        operand_2 = b;
        destReg   = dest;
        md = (op == OP_MUL) || (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM);
        if (md) begin
            e.res  = ref_model(op, a, b);
            e.dest = dest;
            e.cyc  = cyc + XLEN + 1;
            exp_q.push_back(e);
        end
        holds = 0;
        #1;
        while (hold_out === 1'b1 && holds < 100) begin
            holds++;
            @(negedge clk);
            #1;
        end
        chk("hold_cycles", 32'(holds), md ? 32'd33 : 32'd0);
        if (!md) chk("busy_nonmuldiv", {31'd0, busy}, 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_result: got result %h dest %0d, expected no result",
                         result, result_dest);
            end else begin
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("result_dest", {27'd0, result_dest}, {27'd0, e.dest});
                chk("result_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        rst       = 1'b1;
        valid_in  = 1'b0;
        aluctrl   = '0;
        operand_1 = '0;
        operand_2 = '0;
        destReg   = '0;
        kill      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_hold_out", {31'd0, hold_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_result_dest", {27'd0, result_dest}, 32'd0);
        rst = 1'b0;

        // Consecutive directed ops also exercise back-to-back starts 34 cycles apart
        issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd2);
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd3);
        issue(OP_DIVU, 32'hFFFF_FFFE, 32'd2, 5'd4);
        issue(OP_DIV, 32'd5, 32'd0, 5'd5);
        issue(OP_REM, 32'd5, 32'd0, 5'd6);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
        issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        issue(OP_REM, 32'hFFFF_FFF9, 32'd0, 5'd9);
        issue(OP_ADD, 32'd3, 32'd4, 5'd10);

        for (int i = 0; i < 24; i++) begin
            op = (i % 6 == 5) ? OP_ADD : 5'(12 + $urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 100)) : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            issue(op, a, b, 5'($urandom_range(0, 31)));
        end

        // Flush in the middle of BUSY: no result may appear
        @(negedge clk);
        valid_in  = 1'b1;
        aluctrl   = OP_DIV;
        operand_1 = 32'd100;
        operand_2 = 32'd3;
        destReg   = 5'd21;
        repeat (10) @(negedge clk);
        kill = 1'b1;
        #1;
        chk("kill_busy_before", {31'd0, busy}, 32'd1);
        chk("kill_result_valid", {31'd0, result_valid}, 32'd0);
        @(negedge clk);
        kill     = 1'b0;
        valid_in = 1'b0;
        #1;
        chk("kill_busy_after", {31'd0, busy}, 32'd0);
        chk("kill_hold_out_after", {31'd0, hold_out}, 32'd0);
        repeat (40) @(negedge clk);

        // Reset in the middle of BUSY with the instruction still presented
        valid_in  = 1'b1;
        aluctrl   = OP_MUL;
        operand_1 = 32'd123;
        operand_2 = 32'd456;
        destReg   = 5'd17;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_hold_out", {31'd0, hold_out}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_result_valid", {31'd0, result_valid}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_result_dest", {27'd0, result_dest}, 32'd0);
        @(negedge clk);
        valid_in = 1'b0;
        rst      = 1'b0;
        repeat (40) @(negedge clk);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
